hmmm_mem_responder: RTL

- Memory-side responder for the HMMM 8-bit processor bus (Adr[7:0], MemWrite, 16-bit MemData); replaces the board SRAM in FPGA/bench builds.
- Holds a DATA_WIDTH x 2**ADDR_WIDTH word array with a host program-load port.
- Holds the processor in reset until loading completes.
- Captures every processor store into a snoop FIFO so the host can check results (e.g. expected 0x002D store).

---
 rtl/hmmm_mem_responder_if.sv | 37 +++
 rtl/hmmm_mem_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hmmm_mem_responder_if.sv
// Handshake and bus signals between the HMMM memory responder and its host/processor side.
interface hmmm_mem_responder_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  load_start;
   logic [ADDR_WIDTH:0]   load_len;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  cpu_reset;
   logic [ADDR_WIDTH-1:0] bus_adr;
   logic                  bus_memwrite;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic [DATA_WIDTH-1:0] bus_rdata;
   logic                  bus_oe;
   logic                  snoop_valid;
   logic                  snoop_ready;
   logic [ADDR_WIDTH-1:0] snoop_adr;
   logic [DATA_WIDTH-1:0] snoop_data;
   logic                  snoop_ovf;
   logic                  prot_err;

   modport master (
      output load_start, load_len, load_valid, load_data,
      output bus_adr, bus_memwrite, bus_wdata, snoop_ready,
      input  load_ready, cpu_reset, bus_rdata, bus_oe,
      input  snoop_valid, snoop_adr, snoop_data, snoop_ovf, prot_err
   );

   modport slave (
      input  load_start, load_len, load_valid, load_data,
      input  bus_adr, bus_memwrite, bus_wdata, snoop_ready,
      output load_ready, cpu_reset, bus_rdata, bus_oe,
      output snoop_valid, snoop_adr, snoop_data, snoop_ovf, prot_err
   );
endinterface

// File: rtl/hmmm_mem_responder.sv
// HMMM bus memory responder: program-load port, async-read word array and store-snoop FIFO.
// Optional low-address write protection is enabled by defining HMMM_RESPONDER_WRITE_PROTECT_EN.
module hmmm_mem_responder #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int FIFO_DEPTH     = 4,
   parameter int RELEASE_CYCLES = 2,
   parameter int PROTECT_TOP    = 31
) (
   input logic                 ph1,
   input logic                 reset,
   hmmm_mem_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int FAW   = $clog2(FIFO_DEPTH);
   localparam int RW    = $clog2(RELEASE_CYCLES + 1);
   localparam logic [ADDR_WIDTH:0]   LEN_MAX    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [RW-1:0]         REL_LAST   = RW'(RELEASE_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] PROT_TOP_A = ADDR_WIDTH'(PROTECT_TOP);
`ifdef HMMM_RESPONDER_WRITE_PROTECT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH:0]   ptr, ptr_n, len_q, len_n, len_c;
   logic [RW-1:0]         rel_cnt, rel_cnt_n;
   logic                  load_we, cpu_rst_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [FAW:0]          wr_ptr, rd_ptr;
   logic [ADDR_WIDTH-1:0] fifo_adr  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic                  fifo_full, fifo_empty, push, pop, cpu_write, prot_hit;
   logic                  ovf_q, prot_q;

   // Oversized lengths fill the whole array exactly once; the pointer never wraps.
   assign len_c = (bus.load_len > LEN_MAX) ? LEN_MAX : bus.load_len;

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      len_n     = len_q;
      rel_cnt_n = rel_cnt;
      load_we   = 1'b0;
      if (bus.load_start) begin
         ptr_n     = '0;
         rel_cnt_n = '0;
         len_n     = len_c;
         state_n   = (len_c == '0) ? RELEASE : LOAD;
      end else begin
         unique case (state)
            LOAD: begin
               if (bus.load_valid) begin
                  load_we = 1'b1;
                  ptr_n   = ptr + 1'b1;
                  if (ptr == len_q - 1'b1) begin
                     state_n   = RELEASE;
                     rel_cnt_n = '0;
                  end
               end
            end
            RELEASE: begin
               if (rel_cnt == REL_LAST) state_n = RUN;
               else                     rel_cnt_n = rel_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         len_q     <= '0;
         rel_cnt   <= '0;
         cpu_rst_q <= 1'b1;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         len_q     <= len_n;
         rel_cnt   <= rel_cnt_n;
         cpu_rst_q <= (state_n != RUN);
      end
   end

   assign cpu_write = (state == RUN) && bus.bus_memwrite;
   assign prot_hit  = PROT_EN && (bus.bus_adr <= PROT_TOP_A);
   assign push      = cpu_write && !prot_hit;
   assign pop       = !fifo_empty && bus.snoop_ready;

   // Host load and processor store are exclusive by state, so one write port suffices.
   always_ff @(posedge ph1) begin
      if (!reset) begin
         if (load_we)   mem[ptr[ADDR_WIDTH-1:0]] <= bus.load_data;
         else if (push) mem[bus.bus_adr]         <= bus.bus_wdata;
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) &&
                       (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);

   always_ff @(posedge ph1) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         prot_q <= 1'b0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push) begin
            if (fifo_full && !pop) ovf_q  <= 1'b1;
            else                   wr_ptr <= wr_ptr + 1'b1;
         end
         if (cpu_write && prot_hit) prot_q <= 1'b1;
      end
   end

   // A pop frees the head slot in the same cycle, so a push while full still lands.
   always_ff @(posedge ph1) begin
      if (push && (!fifo_full || pop)) begin
         fifo_adr[wr_ptr[FAW-1:0]]  <= bus.bus_adr;
         fifo_data[wr_ptr[FAW-1:0]] <= bus.bus_wdata;
      end
   end

   assign bus.load_ready  = (state == LOAD);
   assign bus.cpu_reset   = cpu_rst_q;
   assign bus.bus_rdata   = mem[bus.bus_adr];
   assign bus.bus_oe      = (state == RUN) && !bus.bus_memwrite;
   assign bus.snoop_valid = !fifo_empty;
   assign bus.snoop_adr   = fifo_adr[rd_ptr[FAW-1:0]];
   assign bus.snoop_data  = fifo_data[rd_ptr[FAW-1:0]];
   assign bus.snoop_ovf   = ovf_q;
   assign bus.prot_err    = prot_q;
endmodule
